// File: rtl/sb_bus_pkg.sv
// Shared definitions for the system-bus master blocks.
// Holds the sequencer state encoding, bus field widths, the full-word
// byte-enable constant and the error-cause codes reported with done.
package sb_bus_pkg;

    localparam int SB_BURST_W = 8;
    localparam int SB_DATA_W  = 32;
    localparam int SB_BE_W    = 4;

    localparam logic [SB_BE_W-1:0] BE_WORD = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEGIN,
        ST_READ,
        ST_WRITE,
        ST_WEND,
        ST_DONE
    } sb_state_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_BUS,
        ERR_SHORT,
        ERR_TIMEOUT,
        ERR_COUNT
    } sb_err_e;

endpackage

// File: rtl/sb_watchdog.sv
// Resettable down-counter watchdog.
// Ports:
//   sys_clk : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : count this cycle
//   kick    : reload to LIMIT (has priority over en)
//   expire  : counter is on its last step; an enabled cycle now runs out
// LIMIT = 0 disables the watchdog (expire never asserts).
module sb_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic en,
    input  logic kick,
    output logic expire
);

    generate
        if (LIMIT == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            localparam int CNT_W = $clog2(LIMIT + 1);

            logic [CNT_W-1:0] count_reg;

            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (kick) begin
                    count_reg <= CNT_W'(LIMIT);
                end else if (en && (count_reg != '0)) begin
                    count_reg <= count_reg - CNT_W'(1);
                end
            end

            // Decoded from state only so the user can qualify it with its
            // own enable without forming a combinational loop.
            assign expire = (count_reg == CNT_W'(1));
        end
    endgenerate

endmodule

// File: rtl/sb_burst_master.sv
// System-bus burst master for the debug unit.
// Takes one command (direction, address, count) per valid/ready handshake,
// requests the bus, issues the begin cycle, streams data beats through the
// rd_* / wr_* ports, and pulses done_o (with err_o) at the end.
// Ports:
//   sb_clock_i / sb_reset_n_i       : clock, async active-low reset
//   cmd_*                           : command handshake (ready only in IDLE)
//   wr_data_i/wr_valid_i/wr_ready_o : write beat stream
//   rd_data_o/rd_valid_o            : read beat strobe (no backpressure)
//   done_o/err_o                    : completion pulse and status
//   sb_request_o/sb_grant_i         : arbiter handshake
//   sb_*_o / sb_*_i                 : OR'd system bus, zero when not owned
module sb_burst_master
    import sb_bus_pkg::*;
#(
    parameter int unsigned MAX_BEATS    = 256,
    parameter int unsigned DATA_TIMEOUT = 1024,
    localparam int         CNT_W        = $clog2(MAX_BEATS) + 1
) (
    input  logic                  sb_clock_i,
    input  logic                  sb_reset_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_read_n_write_i,
    input  logic [SB_DATA_W-1:0]  cmd_address_i,
    input  logic [CNT_W-1:0]      cmd_count_i,
    input  logic [SB_DATA_W-1:0]  wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic [SB_DATA_W-1:0]  rd_data_o,
    output logic                  rd_valid_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  sb_request_o,
    input  logic                  sb_grant_i,
    output logic                  sb_begin_transaction_o,
    output logic                  sb_end_transaction_o,
    output logic                  sb_data_valid_o,
    output logic                  sb_read_n_write_o,
    output logic [SB_DATA_W-1:0]  sb_address_data_o,
    output logic [SB_BE_W-1:0]    sb_byte_enables_o,
    output logic [SB_BURST_W-1:0] sb_burst_size_o,
    input  logic [SB_DATA_W-1:0]  sb_address_data_i,
    input  logic                  sb_end_transaction_i,
    input  logic                  sb_data_valid_i,
    input  logic                  sb_busy_i,
    input  logic                  sb_error_i
);

    sb_state_e state_reg, state_next;
    sb_err_e   cause_reg, cause_next;

    logic                  cmd_rnw_reg, cmd_rnw_next;
    logic [SB_DATA_W-1:0]  cmd_addr_reg, cmd_addr_next;
    logic [CNT_W-1:0]      cmd_count_reg, cmd_count_next;
    logic [CNT_W-1:0]      beat_cnt_reg, beat_cnt_next;   // beats on the bus
    logic [CNT_W-1:0]      load_cnt_reg, load_cnt_next;   // write beats taken in

    logic                  req_reg, req_next;
    logic                  begin_reg, begin_next;
    logic                  end_reg, end_next;
    logic                  dv_reg, dv_next;
    logic                  rnw_reg, rnw_next;
    logic [SB_DATA_W-1:0]  ad_reg, ad_next;
    logic [SB_BE_W-1:0]    be_reg, be_next;
    logic [SB_BURST_W-1:0] bs_reg, bs_next;

    logic [SB_DATA_W-1:0]  rd_data_reg, rd_data_next;
    logic                  rd_valid_reg, rd_valid_next;
    logic                  done_reg, done_next;
    logic                  ready_reg, ready_next;

    logic wr_ready;
    logic wd_en;
    logic wd_kick;
    logic wd_expire;
    logic count_bad;

    assign count_bad = (cmd_count_i == '0) || (cmd_count_i > CNT_W'(MAX_BEATS));

    sb_watchdog #(
        .LIMIT (DATA_TIMEOUT)
    ) u_watchdog (
        .sys_clk (sb_clock_i),
        .rst_n   (sb_reset_n_i),
        .en      (wd_en),
        .kick    (wd_kick),
        .expire  (wd_expire)
    );

    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            state_reg     <= ST_IDLE;
            cause_reg     <= ERR_NONE;
            cmd_rnw_reg   <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_count_reg <= '0;
            beat_cnt_reg  <= '0;
            load_cnt_reg  <= '0;
            req_reg       <= 1'b0;
            begin_reg     <= 1'b0;
            end_reg       <= 1'b0;
            dv_reg        <= 1'b0;
            rnw_reg       <= 1'b0;
            ad_reg        <= '0;
            be_reg        <= '0;
            bs_reg        <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cause_reg     <= cause_next;
            cmd_rnw_reg   <= cmd_rnw_next;
            cmd_addr_reg  <= cmd_addr_next;
            cmd_count_reg <= cmd_count_next;
            beat_cnt_reg  <= beat_cnt_next;
            load_cnt_reg  <= load_cnt_next;
            req_reg       <= req_next;
            begin_reg     <= begin_next;
            end_reg       <= end_next;
            dv_reg        <= dv_next;
            rnw_reg       <= rnw_next;
            ad_reg        <= ad_next;
            be_reg        <= be_next;
            bs_reg        <= bs_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= rd_valid_next;
            done_reg      <= done_next;
            ready_reg     <= ready_next;
        end
    end

    // Bus outputs are registered from the values computed on the transition
    // into a state, so each state sees its own bus values during its cycle.
    // Every bus field defaults to zero, which releases the OR'd bus.
    always_comb begin
        state_next     = state_reg;
        cause_next     = cause_reg;
        cmd_rnw_next   = cmd_rnw_reg;
        cmd_addr_next  = cmd_addr_reg;
        cmd_count_next = cmd_count_reg;
        beat_cnt_next  = beat_cnt_reg;
        load_cnt_next  = load_cnt_reg;
        begin_next     = 1'b0;
        end_next       = 1'b0;
        dv_next        = 1'b0;
        rnw_next       = 1'b0;
        ad_next        = '0;
        be_next        = '0;
        bs_next        = '0;
        rd_data_next   = rd_data_reg;
        rd_valid_next  = 1'b0;
        wr_ready       = 1'b0;
        wd_en          = 1'b0;
        wd_kick        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cause_next = ERR_NONE;
                if (cmd_valid_i) begin
                    cmd_rnw_next   = cmd_read_n_write_i;
                    cmd_addr_next  = cmd_address_i;
                    cmd_count_next = cmd_count_i;
                    if (count_bad) begin
                        state_next = ST_DONE;
                        cause_next = ERR_COUNT;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (sb_grant_i) begin
                    state_next    = ST_BEGIN;
                    begin_next    = 1'b1;
                    ad_next       = cmd_addr_reg;
                    bs_next       = SB_BURST_W'(cmd_count_reg - CNT_W'(1));
                    be_next       = BE_WORD;
                    rnw_next      = cmd_rnw_reg;
                    beat_cnt_next = '0;
                    load_cnt_next = '0;
                end
            end

            ST_BEGIN: begin
                wd_kick = 1'b1;
                if (sb_error_i) begin
                    state_next = ST_DONE;
                    cause_next = ERR_BUS;
                end else begin
                    state_next = cmd_rnw_reg ? ST_READ : ST_WRITE;
                end
            end

            ST_READ: begin
                wd_kick = sb_data_valid_i || sb_end_transaction_i;
                wd_en   = !(sb_data_valid_i || sb_end_transaction_i);
                if (sb_error_i) begin
                    state_next = ST_DONE;
                    cause_next = ERR_BUS;
                end else begin
                    // Beats past the requested count are dropped silently.
                    if (sb_data_valid_i && (beat_cnt_reg < cmd_count_reg)) begin
                        rd_data_next  = sb_address_data_i;
                        rd_valid_next = 1'b1;
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                    if (sb_end_transaction_i) begin
                        state_next = ST_DONE;
                        cause_next = (beat_cnt_next < cmd_count_reg) ? ERR_SHORT : ERR_NONE;
                    end else if (wd_en && wd_expire) begin
                        state_next = ST_DONE;
                        cause_next = ERR_TIMEOUT;
                    end
                end
            end

            ST_WRITE: begin
                if (sb_error_i) begin
                    state_next = ST_DONE;
                    cause_next = ERR_BUS;
                end else begin
                    // The data register can take a new beat when it is empty
                    // or its current beat leaves this cycle.
                    wr_ready = (!dv_reg || !sb_busy_i) && (load_cnt_reg < cmd_count_reg);
                    if (dv_reg && sb_busy_i) begin
                        dv_next = 1'b1;
                        ad_next = ad_reg;
                    end else if (wr_ready && wr_valid_i) begin
                        dv_next       = 1'b1;
                        ad_next       = wr_data_i;
                        load_cnt_next = load_cnt_reg + CNT_W'(1);
                    end
                    if (dv_reg && !sb_busy_i) begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                        if (beat_cnt_next == cmd_count_reg) begin
                            state_next = ST_WEND;
                            end_next   = 1'b1;
                        end
                    end
                end
            end

            ST_WEND: begin
                state_next = ST_DONE;
                if (sb_error_i) begin
                    cause_next = ERR_BUS;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        req_next   = (state_next == ST_REQ);
        done_next  = (state_next == ST_DONE);
        ready_next = (state_next == ST_IDLE);
    end

    assign cmd_ready_o            = ready_reg;
    assign wr_ready_o             = wr_ready;
    assign rd_data_o              = rd_data_reg;
    assign rd_valid_o             = rd_valid_reg;
    assign done_o                 = done_reg;
    assign err_o                  = done_reg && (cause_reg != ERR_NONE);
    assign sb_request_o           = req_reg;
    assign sb_begin_transaction_o = begin_reg;
    assign sb_end_transaction_o   = end_reg;
    assign sb_data_valid_o        = dv_reg;
    assign sb_read_n_write_o      = rnw_reg;
    assign sb_address_data_o      = ad_reg;
    assign sb_byte_enables_o      = be_reg;
    assign sb_burst_size_o        = bs_reg;

endmodule

// File: tb/tb_sb_burst_master.sv
module tb_sb_burst_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_read_n_write_i;
    logic [31:0] cmd_address_i;
    logic [8:0]  cmd_count_i;
    logic [31:0] wr_data_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        done_o;
    logic        err_o;
    logic        sb_request_o;
    logic        sb_grant_i;
    logic        sb_begin_transaction_o;
    logic        sb_end_transaction_o;
    logic        sb_data_valid_o;
    logic        sb_read_n_write_o;
    logic [31:0] sb_address_data_o;
    logic [3:0]  sb_byte_enables_o;
    logic [7:0]  sb_burst_size_o;
    logic [31:0] sb_address_data_i;
    logic        sb_end_transaction_i;
    logic        sb_data_valid_i;
    logic        sb_busy_i;
    logic        sb_error_i;

    int checks = 0;
    int errors = 0;

    int end_cnt = 0;
    int rdv_cnt = 0;
    int req_cnt = 0;
    logic [31:0] wq[$];
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data = '0;

    sb_burst_master #(
        .MAX_BEATS    (256),
        .DATA_TIMEOUT (16)
    ) dut (
        .sb_clock_i             (clk),
        .sb_reset_n_i           (rst_n),
        .cmd_valid_i            (cmd_valid_i),
        .cmd_ready_o            (cmd_ready_o),
        .cmd_read_n_write_i     (cmd_read_n_write_i),
        .cmd_address_i          (cmd_address_i),
        .cmd_count_i            (cmd_count_i),
        .wr_data_i              (wr_data_i),
        .wr_valid_i             (wr_valid_i),
        .wr_ready_o             (wr_ready_o),
        .rd_data_o              (rd_data_o),
        .rd_valid_o             (rd_valid_o),
        .done_o                 (done_o),
        .err_o                  (err_o),
        .sb_request_o           (sb_request_o),
        .sb_grant_i             (sb_grant_i),
        .sb_begin_transaction_o (sb_begin_transaction_o),
        .sb_end_transaction_o   (sb_end_transaction_o),
        .sb_data_valid_o        (sb_data_valid_o),
        .sb_read_n_write_o      (sb_read_n_write_o),
        .sb_address_data_o      (sb_address_data_o),
        .sb_byte_enables_o      (sb_byte_enables_o),
        .sb_burst_size_o        (sb_burst_size_o),
        .sb_address_data_i      (sb_address_data_i),
        .sb_end_transaction_i   (sb_end_transaction_i),
        .sb_data_valid_i        (sb_data_valid_i),
        .sb_busy_i              (sb_busy_i),
        .sb_error_i             (sb_error_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: pulse counters, accepted write beats, busy-hold rule.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_end_transaction_o) end_cnt <= end_cnt + 1;
            if (rd_valid_o)           rdv_cnt <= rdv_cnt + 1;
            if (sb_request_o)         req_cnt <= req_cnt + 1;
            if (sb_data_valid_o && !sb_busy_i && !sb_error_i) wq.push_back(sb_address_data_o);
            if (hold_pending) begin
                check("hold_dv", {31'd0, sb_data_valid_o}, 32'd1);
                check("hold_data", sb_address_data_o, hold_data);
            end
        end
        hold_pending <= rst_n && sb_data_valid_o && sb_busy_i && !sb_error_i;
        hold_data    <= sb_address_data_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready_o) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_cmd(input logic rnw, input logic [31:0] addr, input logic [8:0] cnt);
        wait_ready();
        cmd_read_n_write_i = rnw;
        cmd_address_i      = addr;
        cmd_count_i        = cnt;
        cmd_valid_i        = 1'b1;
        tick();
        cmd_valid_i        = 1'b0;
    endtask

    // Entered in the REQ cycle; returns in the BEGIN cycle.
    task automatic grant_bus();
        check("req_high", {31'd0, sb_request_o}, 32'd1);
        tick();
        check("req_hold", {31'd0, sb_request_o}, 32'd1);
        sb_grant_i = 1'b1;
        tick();
        sb_grant_i = 1'b0;
        check("begin", {31'd0, sb_begin_transaction_o}, 32'd1);
        check("begin_req", {31'd0, sb_request_o}, 32'd0);
        check("begin_be", {28'd0, sb_byte_enables_o}, 32'hF);
    endtask

    // Streams n write beats base, base+1, ...; returns in the WEND cycle.
    task automatic write_burst(input logic [31:0] base, input int n, input int gap_every,
                               input int busy_len, output int bubbles);
        int loaded = 0;
        int busy_left = busy_len;
        logic seen_end = 1'b0;
        bubbles = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (sb_end_transaction_o) begin
                seen_end = 1'b1;
                break;
            end
            check("wr_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
            if (wq.size() > 0 && !sb_data_valid_o) bubbles++;
            wr_valid_i = (loaded < n) && !(gap_every != 0 && (cyc % gap_every) == gap_every - 1);
            wr_data_i  = base + loaded;
            sb_busy_i  = 1'b0;
            if (sb_data_valid_o && wq.size() == 1 && busy_left > 0) begin
                sb_busy_i = 1'b1;
                busy_left--;
            end
            #1;
            if (sb_busy_i) check("wr_ready_busy", {31'd0, wr_ready_o}, 32'd0);
            if (wr_valid_i && wr_ready_o) loaded++;
            @(posedge clk);
            #1;
        end
        wr_valid_i = 1'b0;
        sb_busy_i  = 1'b0;
        if (!seen_end) check("wr_end_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_wq(input string tag, input logic [31:0] base, input int n);
        check(tag, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) check(tag, wq[i], base + i);
    endtask

    initial begin
        int e0, r0, q0, bub, k_at;

        rst_n = 1'b1;
        cmd_valid_i = 0; cmd_read_n_write_i = 0; cmd_address_i = 0; cmd_count_i = 0;
        wr_data_i = 0; wr_valid_i = 0; sb_grant_i = 0; sb_address_data_i = 0;
        sb_end_transaction_i = 0; sb_data_valid_i = 0; sb_busy_i = 0; sb_error_i = 0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        check("rst_req", {31'd0, sb_request_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_ad", sb_address_data_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("idle_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Read 1 word at 0x1000
        send_cmd(1'b1, 32'h0000_1000, 9'd1);
        check("rd1_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        grant_bus();
        check("rd1_addr", sb_address_data_o, 32'h0000_1000);
        check("rd1_bsize", {24'd0, sb_burst_size_o}, 32'd0);
        check("rd1_rnw", {31'd0, sb_read_n_write_o}, 32'd1);
        tick();
        check("rd1_bus_idle", {16'd0, sb_begin_transaction_o, sb_end_transaction_o, sb_data_valid_o,
              sb_read_n_write_o, sb_byte_enables_o, sb_burst_size_o}, 32'd0);
        repeat (9) tick();
        sb_data_valid_i = 1'b1; sb_address_data_i = 32'hDEAD_BEEF;
        tick();
        sb_data_valid_i = 1'b0; sb_address_data_i = 32'd0;
        check("rd1_valid", {31'd0, rd_valid_o}, 32'd1);
        check("rd1_data", rd_data_o, 32'hDEAD_BEEF);
        tick();
        check("rd1_strobe", {31'd0, rd_valid_o}, 32'd0);
        tick();
        sb_end_transaction_i = 1'b1;
        tick();
        sb_end_transaction_i = 1'b0;
        check("rd1_done", {31'd0, done_o}, 32'd1);
        check("rd1_err", {31'd0, err_o}, 32'd0);
        tick();
        check("rd1_done_pulse", {31'd0, done_o}, 32'd0);
        $display("txn read1 addr=00001000 data=%h", rd_data_o);

        // Read 4 words, bus error after beat 2
        e0 = end_cnt; r0 = rdv_cnt;
        send_cmd(1'b1, 32'h0000_2000, 9'd4);
        grant_bus();
        check("rd4_bsize", {24'd0, sb_burst_size_o}, 32'd3);
        tick();
        sb_data_valid_i = 1'b1; sb_address_data_i = 32'h0000_00A1;
        tick();
        check("rd4_d1", rd_data_o, 32'h0000_00A1);
        sb_address_data_i = 32'h0000_00A2;
        tick();
        check("rd4_d2", rd_data_o, 32'h0000_00A2);
        sb_data_valid_i = 1'b0; sb_address_data_i = 32'd0; sb_error_i = 1'b1;
        tick();
        sb_error_i = 1'b0;
        check("rd4_done", {31'd0, done_o}, 32'd1);
        check("rd4_err", {31'd0, err_o}, 32'd1);
        check("rd4_bus_zero", {16'd0, sb_begin_transaction_o, sb_end_transaction_o, sb_data_valid_o,
              sb_read_n_write_o, sb_byte_enables_o, sb_burst_size_o}, 32'd0);
        tick();
        check("rd4_strobes", rdv_cnt - r0, 32'd2);
        check("rd4_no_end", end_cnt - e0, 32'd0);
        $display("txn read4 addr=00002000 aborted err=1");

        // Write 4 words with busy during beat 2
        e0 = end_cnt;
        send_cmd(1'b0, 32'h0000_3000, 9'd4);
        grant_bus();
        check("wr4_addr", sb_address_data_o, 32'h0000_3000);
        check("wr4_rnw", {31'd0, sb_read_n_write_o}, 32'd0);
        check("wr4_bsize", {24'd0, sb_burst_size_o}, 32'd3);
        wq.delete();
        write_burst(32'd1, 4, 0, 5, bub);
        check("wr4_end", {31'd0, sb_end_transaction_o}, 32'd1);
        check("wr4_dv_off", {31'd0, sb_data_valid_o}, 32'd0);
        check("wr4_bubbles", bub, 32'd0);
        tick();
        check("wr4_done", {31'd0, done_o}, 32'd1);
        check("wr4_err", {31'd0, err_o}, 32'd0);
        check("wr4_end_cnt", end_cnt - e0, 32'd1);
        check_wq("wr4_beat", 32'd1, 4);
        $display("txn write4 addr=00003000 beats=%0d", wq.size());

        // Write 3 with gaps, second command queued mid-burst
        send_cmd(1'b0, 32'h0000_4000, 9'd3);
        grant_bus();
        cmd_read_n_write_i = 1'b0; cmd_address_i = 32'h0000_4100; cmd_count_i = 9'd2;
        cmd_valid_i = 1'b1;
        wq.delete();
        write_burst(32'h10, 3, 3, 0, bub);
        check("gap_bubbles", {31'd0, bub > 0}, 32'd1);
        tick();
        check("gap_done", {31'd0, done_o}, 32'd1);
        check("gap_ready_done", {31'd0, cmd_ready_o}, 32'd0);
        check_wq("gap_beat", 32'h10, 3);
        $display("txn write3 addr=00004000 bubbles=%0d", bub);
        wait_ready();
        tick();
        cmd_valid_i = 1'b0;
        grant_bus();
        check("cmd2_addr", sb_address_data_o, 32'h0000_4100);
        wq.delete();
        write_burst(32'h20, 2, 0, 0, bub);
        tick();
        check("cmd2_done", {31'd0, done_o}, 32'd1);
        check("cmd2_err", {31'd0, err_o}, 32'd0);
        check_wq("cmd2_beat", 32'h20, 2);
        $display("txn write2 addr=00004100 beats=%0d", wq.size());

        // Silent slave: timeout
        send_cmd(1'b1, 32'h0000_5000, 9'd2);
        grant_bus();
        k_at = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_o) begin
                k_at = k;
                break;
            end
        end
        check("to_cycles", k_at, 32'd17);
        check("to_err", {31'd0, err_o}, 32'd1);
        $display("txn read_timeout addr=00005000 cycles=%0d", k_at);

        // Bad counts: 0 and MAX_BEATS+1
        q0 = req_cnt;
        send_cmd(1'b1, 32'h0000_6000, 9'd0);
        check("cnt0_done", {31'd0, done_o}, 32'd1);
        check("cnt0_err", {31'd0, err_o}, 32'd1);
        tick();
        send_cmd(1'b0, 32'h0000_6000, 9'd257);
        check("cnt257_done", {31'd0, done_o}, 32'd1);
        check("cnt257_err", {31'd0, err_o}, 32'd1);
        tick();
        check("cnt_no_req", req_cnt - q0, 32'd0);
        $display("txn bad_count err=1");

        // Reset mid-write
        send_cmd(1'b0, 32'h0000_7000, 9'd3);
        grant_bus();
        wr_valid_i = 1'b1; wr_data_i = 32'h0000_00A5;
        tick();
        tick();
        check("mid_dv", {31'd0, sb_data_valid_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dv", {31'd0, sb_data_valid_o}, 32'd0);
        check("arst_ad", sb_address_data_o, 32'd0);
        check("arst_wr_ready", {31'd0, wr_ready_o}, 32'd0);
        check("arst_ready", {31'd0, cmd_ready_o}, 32'd0);
        wr_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        send_cmd(1'b1, 32'h0000_8000, 9'd1);
        grant_bus();
        tick();
        sb_data_valid_i = 1'b1; sb_address_data_i = 32'h1234_5678;
        tick();
        sb_data_valid_i = 1'b0; sb_address_data_i = 32'd0;
        check("post_rst_data", rd_data_o, 32'h1234_5678);
        sb_end_transaction_i = 1'b1;
        tick();
        sb_end_transaction_i = 1'b0;
        check("post_rst_done", {31'd0, done_o}, 32'd1);
        check("post_rst_err", {31'd0, err_o}, 32'd0);
        $display("txn read_after_reset addr=00008000 data=%h", rd_data_o);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
